// File: rtl/wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_stage: MEM/WB pipeline register, register-file write select, forwarding |
// | value and retired-instruction counter.                                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wb_stage #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int REG_SEL   = $clog2(NUM_REGS),
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_in,
  input  logic                 flush_in,
  input  logic                 valid_in,
  input  logic                 reg_write,
  input  logic                 mem_read,
  input  logic                 jump,
  input  logic [REG_SEL-1:0]   rd,
  input  logic [WORD_SIZE-1:0] result,
  input  logic [WORD_SIZE-1:0] pc_plus4,
  input  logic [WORD_SIZE-1:0] read_data,
  output logic                 wb_en,
  output logic [REG_SEL-1:0]   wb_rd,
  output logic [WORD_SIZE-1:0] wb_data,
  output logic [CNT_WIDTH-1:0] retired_count
);

  logic                 r_valid;
  logic                 r_reg_write;
  logic                 r_mem_read;
  logic                 r_jump;
  logic [REG_SEL-1:0]   r_rd;
  logic [WORD_SIZE-1:0] r_result;
  logic [WORD_SIZE-1:0] r_pc4;
  logic [WORD_SIZE-1:0] r_hold;
  logic                 r_fresh;
  logic [CNT_WIDTH-1:0] r_retired;

  logic                 w_retire;
  logic [WORD_SIZE-1:0] w_load_data;

  // A flush still lets the instruction currently in WB leave, so it retires.
  assign w_retire = r_valid & (~stall_in | flush_in);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_jump      <= 1'b0;
      r_rd        <= '0;
      r_result    <= '0;
      r_pc4       <= '0;
      r_hold      <= '0;
      r_fresh     <= 1'b0;
      r_retired   <= '0;
    end else begin
      if (w_retire) begin
        r_retired <= r_retired + CNT_WIDTH'(1);
      end
      // Latch live load data after its first WB cycle; a capture below may re-arm.
      if (r_fresh) begin
        r_hold  <= read_data;
        r_fresh <= 1'b0;
      end
      if (flush_in) begin
        r_valid <= 1'b0;
      end else if (!stall_in) begin
        r_valid     <= valid_in;
        r_reg_write <= reg_write;
        r_mem_read  <= mem_read;
        r_jump      <= jump;
        r_rd        <= rd;
        r_result    <= result;
        r_pc4       <= pc_plus4;
        r_fresh     <= mem_read & valid_in;
      end
    end
  end

  assign w_load_data = r_fresh ? read_data : r_hold;

  always_comb begin
    wb_data = r_result;
    if (r_jump) begin
      wb_data = r_pc4;
    end else if (r_mem_read) begin
      wb_data = w_load_data;
    end
  end

  assign wb_en         = r_valid & r_reg_write & (r_rd != '0);
  assign wb_rd         = r_rd;
  assign retired_count = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// Testbench for wb_stage: directed scenarios followed by randomized traffic,
// checked against an instruction-level model of the writeback slot.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in, flush_in, valid_in, reg_write, mem_read, jump;
  logic [4:0]  rd;
  logic [31:0] result, pc_plus4, read_data;
  logic        wb_en, wb_en4;
  logic [4:0]  wb_rd, wb_rd4;
  logic [31:0] wb_data, wb_data4;
  logic [63:0] retired_count;
  logic [3:0]  retired_count4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .reg_write(reg_write), .mem_read(mem_read), .jump(jump),
    .rd(rd), .result(result), .pc_plus4(pc_plus4), .read_data(read_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .retired_count(retired_count)
  );

  wb_stage #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .reg_write(reg_write), .mem_read(mem_read), .jump(jump),
    .rd(rd), .result(result), .pc_plus4(pc_plus4), .read_data(read_data),
    .wb_en(wb_en4), .wb_rd(wb_rd4), .wb_data(wb_data4), .retired_count(retired_count4)
  );

  // Model of the instruction sitting in WB.
  logic        m_valid, m_writes, m_is_load, m_is_jump, m_known, m_load_first;
  logic [4:0]  m_rd;
  logic [31:0] m_value, m_load_value;
  logic [63:0] m_count;

  task automatic model_edge();
    if (!rst) begin
      m_valid = 0; m_writes = 0; m_is_load = 0; m_is_jump = 0;
      m_rd = 0; m_value = 0; m_load_value = 0; m_load_first = 0;
      m_known = 1; m_count = 0;
    end else begin
      if (m_valid && (!stall_in || flush_in)) m_count = m_count + 1;
      if (m_load_first) begin
        m_load_value = read_data;
        m_load_first = 0;
      end
      if (flush_in) begin
        m_valid = 0;
        m_known = 0;
      end else if (!stall_in) begin
        m_valid      = valid_in;
        m_writes     = reg_write;
        m_is_load    = mem_read;
        m_is_jump    = jump;
        m_rd         = rd;
        m_value      = jump ? pc_plus4 : result;
        m_load_first = mem_read & valid_in;
        m_known      = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_data;
    #1;
    if (m_is_jump)      exp_data = m_value;
    else if (m_is_load) exp_data = m_load_first ? read_data : m_load_value;
    else                exp_data = m_value;
    chk({tag, "_en"}, 64'(wb_en), 64'(m_valid & m_writes & (m_rd != 0)));
    if (m_known) begin
      chk({tag, "_rd"}, 64'(wb_rd), 64'(m_rd));
      chk({tag, "_data"}, 64'(wb_data), 64'(exp_data));
    end
    chk({tag, "_cnt"}, retired_count, m_count);
    chk({tag, "_cnt4"}, 64'(retired_count4), 64'(m_count[3:0]));
  endtask

  task automatic idle();
    rst = 1; stall_in = 0; flush_in = 0; valid_in = 0; reg_write = 0;
    mem_read = 0; jump = 0; rd = 0; result = $urandom; pc_plus4 = $urandom;
    read_data = $urandom;
  endtask

  task automatic randomize_inputs();
    stall_in  = ($urandom_range(0, 3) == 0);
    flush_in  = ($urandom_range(0, 9) == 0);
    valid_in  = $urandom_range(0, 1);
    reg_write = $urandom_range(0, 1);
    mem_read  = $urandom_range(0, 1);
    jump      = ($urandom_range(0, 3) == 0);
    rd        = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
    result    = $urandom;
    pc_plus4  = $urandom;
    read_data = $urandom;
  endtask

  initial begin
    logic [63:0] base;
    m_valid = 0; m_writes = 0; m_is_load = 0; m_is_jump = 0; m_known = 0;
    m_load_first = 0; m_rd = 0; m_value = 0; m_load_value = 0; m_count = 0;

    // Reset with random inputs
    randomize_inputs(); rst = 0; tick();
    randomize_inputs(); rst = 0; tick();
    idle();
    #1;
    chk("t1_en", 64'(wb_en), 64'd0);
    chk("t1_rd", 64'(wb_rd), 64'd0);
    chk("t1_data", 64'(wb_data), 64'd0);
    chk("t1_cnt", retired_count, 64'd0);

    // ALU op
    valid_in = 1; reg_write = 1; rd = 5; result = 32'h1234_5678; tick();
    idle();
    check_all("t2");
    chk("t2_en_c", 64'(wb_en), 64'd1);
    chk("t2_rd_c", 64'(wb_rd), 64'd5);
    chk("t2_data_c", 64'(wb_data), 64'h1234_5678);
    tick();
    chk("t2_cnt_c", retired_count, 64'd1);

    // Load held across a 3-cycle stall while d_mem output changes
    valid_in = 1; reg_write = 1; mem_read = 1; rd = 7; tick();
    idle();
    base = retired_count;
    for (int i = 0; i < 4; i++) begin
      stall_in  = (i < 3);
      read_data = (i == 0) ? 32'hDEAD_BEEF : 32'h0;
      check_all("t3");
      chk("t3_data_c", 64'(wb_data), 64'hDEAD_BEEF);
      chk("t3_en_c", 64'(wb_en), 64'd1);
      chk("t3_cnt_c", retired_count, base);
      tick();
    end
    idle();
    chk("t3_cnt_after", retired_count, base + 1);

    // Jump then write to x0
    base = retired_count;
    valid_in = 1; reg_write = 1; jump = 1; pc_plus4 = 32'h104; rd = 1; tick();
    idle();
    valid_in = 1; reg_write = 1; rd = 0; result = 32'hCAFE_0001;
    check_all("t4a");
    chk("t4_data_c", 64'(wb_data), 64'h104);
    chk("t4_en_c", 64'(wb_en), 64'd1);
    tick();
    idle();
    check_all("t4b");
    chk("t4_x0_en", 64'(wb_en), 64'd0);
    tick();
    chk("t4_cnt", retired_count, base + 2);

    // Flush and stall together
    valid_in = 1; reg_write = 1; rd = 9; result = 32'h5555_AAAA; tick();
    idle();
    base = retired_count;
    flush_in = 1; stall_in = 1;
    check_all("t5a");
    chk("t5_en_before", 64'(wb_en), 64'd1);
    tick();
    idle();
    check_all("t5b");
    chk("t5_en_after", 64'(wb_en), 64'd0);
    chk("t5_cnt", retired_count, base + 1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      rst = ($urandom_range(0, 59) != 0);
      check_all("rnd");
      tick();
    end

    // Counter wrap on the 4-bit instance
    idle(); rst = 0; tick();
    idle();
    for (int i = 0; i < 17; i++) begin
      valid_in = 1; reg_write = 1; rd = 5'($urandom); result = $urandom;
      tick();
    end
    idle(); tick();
    check_all("t6");
    chk("t6_wrap", 64'(retired_count4), 64'd1);
    chk("t6_cnt64", retired_count, 64'd17);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
